// File: rtl/display_bcd7seg.sv
// Display stage for the divisor: captures the quotient on a rising done, converts it to
// 3-digit BCD with a sequential double-dabble and scans a 3-digit common-anode display.
module display_bcd7seg #(
    parameter int REFRESH_CNT = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        done,
    input  logic [7:0]  resultado,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int CW = $clog2(REFRESH_CNT);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state, state_n;
    logic            done_q;
    logic            start;
    logic [19:0]     sh, sh_n;
    logic [11:0]     adj;
    logic [2:0]      bitcnt;
    logic [CW-1:0]   rcnt;
    logic            wrap;
    logic [1:0]      idx, idx_n;
    logic [3:0]      digit;
    logic            blank;
    logic [2:0]      an_n;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign start = done & ~done_q;
    assign busy  = (state == CONV);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CONV;
            CONV:    if (bitcnt == 3'd7) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Double-dabble step: adjust every BCD nibble, then shift the whole register left.
    always_comb begin
        adj  = {add3(sh[19:16]), add3(sh[15:12]), add3(sh[11:8])};
        sh_n = {adj[10:0], sh[7:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q    <= 1'b0;
            state     <= IDLE;
            bitcnt    <= 3'd0;
            bcd       <= 12'd0;
            bcd_valid <= 1'b0;
        end else begin
            done_q    <= done;
            state     <= state_n;
            bcd_valid <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sh     <= {12'd0, resultado};
                    bitcnt <= 3'd0;
                end
            end else begin
                sh     <= sh_n;
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    bcd       <= sh_n[19:8];
                    bcd_valid <= 1'b1;
                end
            end
        end
    end

    // Scan selection is computed for the upcoming digit so seg/an move with idx.
    always_comb begin
        wrap  = (rcnt == CW'(REFRESH_CNT - 1));
        idx_n = idx;
        if (wrap) idx_n = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        digit = bcd[3:0];
        an_n  = 3'b110;
        blank = 1'b0;
        case (idx_n)
            2'd1: begin
                digit = bcd[7:4];
                an_n  = 3'b101;
                blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            2'd2: begin
                digit = bcd[11:8];
                an_n  = 3'b011;
                blank = (bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt <= '0;
            idx  <= 2'd0;
            an   <= 3'b110;
            seg  <= 7'b1000000;
        end else begin
            rcnt <= wrap ? '0 : rcnt + CW'(1);
            idx  <= idx_n;
            an   <= blank ? 3'b111 : an_n;
            seg  <= blank ? 7'b1111111 : seg_decode(digit);
        end
    end

endmodule
